// File: rtl/pio_btn_debounced_pkg.sv
// pio_btn_pkg: shared definitions for the debounced button PIO.
//   - register addresses for the Avalon-MM register map
//   - debounce FSM state type
//   - cnt_width(): width of a counter that must hold 0..n
package pio_btn_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RISE = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_FALL = 3'd4;
    localparam logic [2:0] ADDR_RAW  = 3'd5;

    typedef enum logic {
        DEB_STABLE,
        DEB_COUNTING
    } deb_state_e;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pio_btn_debounced_if.sv
// pio_btn_debounced_if: Avalon-MM slave bus of the button PIO.
//   address[2:0], chipselect, write_n, writedata[WIDTH] : master -> slave
//   readdata[WIDTH] (registered), irq (level)           : slave -> master
interface pio_btn_debounced_if #(
    parameter int WIDTH = 3
);
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    logic             irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_btn_debounced_debounce_ch.sv
// pio_btn_debounce_ch: one input channel -- synchroniser chain followed by
// a counter-based debounce FSM.
//   clk, reset_n : clock, asynchronous active-low reset
//   pin          : raw asynchronous input
//   sync_out     : last synchroniser stage (only with PIO_BTN_RAW_READ_EN)
//   deb          : debounced level
module pio_btn_debounce_ch
    import pio_btn_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
`ifdef PIO_BTN_RAW_READ_EN
    output logic sync_out,
`endif
    output logic deb
);
    localparam int            CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    deb_state_e             state;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
`ifdef PIO_BTN_RAW_READ_EN
    assign sync_out = sync_in;
`endif

    // The clock that first sees sync_in != deb counts as stable clock 1, so
    // deb takes the new level DEB_CYCLES clocks after it reaches sync_in.
    // Any return to the old level before then discards the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DEB_STABLE;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            case (state)
                DEB_STABLE: begin
                    if (sync_in != deb) begin
                        if (DEB_CYCLES == 1) begin
                            deb <= sync_in;
                        end else begin
                            state <= DEB_COUNTING;
                            cnt   <= CW'(1);
                        end
                    end
                end
                DEB_COUNTING: begin
                    if (sync_in == deb) begin
                        state <= DEB_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        deb   <= sync_in;
                        state <= DEB_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= DEB_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pio_btn_debounced.sv
// pio_btn_debounced: Avalon-MM input PIO for buttons/switches with per-channel
// synchronisation, debounce, per-bit rise/fall edge capture (W1C) and a
// masked level IRQ.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon slave (address, chipselect, write_n, writedata,
//                  readdata registered 1 cycle, irq)
//   in_port      : raw asynchronous pins
// Register map: 0 data (RO), 1 rise_en, 2 irq_mask, 3 edge_capture (W1C),
// 4 fall_en, 5 raw synchronised inputs when PIO_BTN_RAW_READ_EN is defined
// (otherwise reads 0 like any unmapped address).
module pio_btn_debounced
    import pio_btn_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 50000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pio_btn_debounced_if.slave     bus,
    input  logic [WIDTH-1:0]       in_port
);
    logic [WIDTH-1:0] deb, deb_d;
    logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_capture;
    logic [WIDTH-1:0] edge_detect, w1c, rd_mux;
    logic             wr;
`ifdef PIO_BTN_RAW_READ_EN
    logic [WIDTH-1:0] sync_in;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pio_btn_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin      (in_port[i]),
`ifdef PIO_BTN_RAW_READ_EN
            .sync_out (sync_in[i]),
`endif
            .deb      (deb[i])
        );
    end

    assign wr          = bus.chipselect & ~bus.write_n;
    assign w1c         = (wr && bus.address == ADDR_EDGE) ? bus.writedata : '0;
    assign edge_detect = (deb & ~deb_d & rise_en) | (~deb & deb_d & fall_en);
    assign bus.irq     = |(edge_capture & irq_mask);

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux = deb;
            ADDR_RISE: rd_mux = rise_en;
            ADDR_MASK: rd_mux = irq_mask;
            ADDR_EDGE: rd_mux = edge_capture;
            ADDR_FALL: rd_mux = fall_en;
`ifdef PIO_BTN_RAW_READ_EN
            ADDR_RAW:  rd_mux = sync_in;
`endif
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d        <= '0;
            rise_en      <= '1;
            fall_en      <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            bus.readdata <= '0;
        end else begin
            deb_d <= deb;
            if (wr && bus.address == ADDR_RISE) rise_en  <= bus.writedata;
            if (wr && bus.address == ADDR_FALL) fall_en  <= bus.writedata;
            if (wr && bus.address == ADDR_MASK) irq_mask <= bus.writedata;
            // Set is OR-ed in after the clear so a same-cycle edge survives.
            edge_capture <= (edge_capture & ~w1c) | edge_detect;
            bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_btn_debounced.sv
// Testbench for pio_btn_debounced (WIDTH=3, SYNC_STAGES=2, DEB_CYCLES=4).
// A reference model predicts readdata and irq per clock into queues; a
// monitor on the falling edge pops and compares. Directed scenarios add
// fixed-value checks of latency and corner cases.
module tb_pio_btn_debounced;
    localparam int W  = 3;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;

    pio_btn_debounced_if #(.WIDTH(W)) bus ();

    pio_btn_debounced #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .DEB_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] rd_q[$];
    logic         irq_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // deb flips when the last DC sampled sync_in values all differ from it.
    logic [W-1:0] m_pipe[SS];
    logic [W-1:0] m_hist[DC];
    logic [W-1:0] m_deb, m_deb_d, m_ec, m_mask, m_rise, m_fall;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_pipe[i] = '0;
        for (int i = 0; i < DC; i++) m_hist[i] = '0;
        m_deb = '0; m_deb_d = '0; m_ec = '0; m_mask = '0;
        m_rise = '1; m_fall = '0;
        rd_q.delete();
        irq_q.delete();
    endtask

    task automatic model_step();
        logic [W-1:0] rd, edet;
        logic         wr;
        int           diff;
        case (bus.address)
            3'd0:    rd = m_deb;
            3'd1:    rd = m_rise;
            3'd2:    rd = m_mask;
            3'd3:    rd = m_ec;
            3'd4:    rd = m_fall;
            default: rd = '0;
        endcase
        rd_q.push_back(rd);
        edet = (m_deb & ~m_deb_d & m_rise) | (~m_deb & m_deb_d & m_fall);
        wr   = bus.chipselect && !bus.write_n;
        if (wr && bus.address == 3'd3) m_ec = (m_ec & ~bus.writedata) | edet;
        else                           m_ec = m_ec | edet;
        if (wr && bus.address == 3'd1) m_rise = bus.writedata;
        if (wr && bus.address == 3'd2) m_mask = bus.writedata;
        if (wr && bus.address == 3'd4) m_fall = bus.writedata;
        m_deb_d = m_deb;
        for (int i = DC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_pipe[SS-1];
        for (int b = 0; b < W; b++) begin
            diff = 0;
            for (int i = 0; i < DC; i++) if (m_hist[i][b] != m_deb[b]) diff++;
            if (diff == DC) m_deb[b] = m_hist[0][b];
        end
        for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = in_port;
        irq_q.push_back(|(m_ec & m_mask));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_irq", 32'(bus.irq), 32'd0);
                chk("rst_readdata", 32'(bus.readdata), 32'd0);
            end else begin
                if (rd_q.size() > 0) chk("sb_readdata", 32'(bus.readdata), 32'(rd_q.pop_front()));
                if (irq_q.size() > 0) chk("sb_irq", 32'(bus.irq), 32'(irq_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold[W];
    int r;

    initial begin
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        wait_neg(3);
        #1 reset_n = 1'b1;

        // 1: reset values
        @(negedge clk); bus.address = 3'd1;
        @(negedge clk); chk("rst_rise_en", 32'(bus.readdata), 32'd7); bus.address = 3'd4;
        @(negedge clk); chk("rst_fall_en", 32'(bus.readdata), 32'd0); bus.address = 3'd0;
        @(negedge clk); chk("rst_data", 32'(bus.readdata), 32'd0);
        chk("rst_irq0", 32'(bus.irq), 32'd0);

        // 2: rising edge latency, irq with mask bit 0
        bus_write(3'd2, 3'b001);
        bus.address = 3'd0; in_port[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) begin
                chk("lat_data_k6", 32'(bus.readdata), 32'd0);
                chk("lat_irq_k6", 32'(bus.irq), 32'd0);
            end
            if (k == 7) begin
                chk("lat_data_k7", 32'(bus.readdata), 32'd1);
                chk("lat_irq_k7", 32'(bus.irq), 32'd1);
            end
        end
        bus.address = 3'd3;
        @(negedge clk); chk("lat_edge", 32'(bus.readdata), 32'd1);
        bus_write(3'd3, 3'b001);
        chk("w1c_irq_drop", 32'(bus.irq), 32'd0);

        // 5: W1C in the same cycle as edge_detect -> set wins
        in_port[0] = 1'b0; wait_neg(10);
        in_port[0] = 1'b1; wait_neg(5);
        bus_write(3'd3, 3'b001);
        bus.address = 3'd3;
        @(negedge clk);
        chk("w1c_vs_set_edge", 32'(bus.readdata), 32'd1);
        chk("w1c_vs_set_irq", 32'(bus.irq), 32'd1);

        // 3: short glitch is discarded
        bus_write(3'd3, 3'b111);
        bus_write(3'd2, 3'b111);
        in_port[1] = 1'b1; wait_neg(3);
        in_port[1] = 1'b0; bus.address = 3'd3; wait_neg(10);
        chk("glitch_edge", 32'(bus.readdata), 32'd0);
        chk("glitch_irq", 32'(bus.irq), 32'd0);
        bus.address = 3'd0;
        @(negedge clk); chk("glitch_data", 32'(bus.readdata), 32'd1);

        // 4: fall-only capture on bit 2
        bus_write(3'd4, 3'b100);
        bus_write(3'd1, 3'b000);
        in_port[2] = 1'b1; bus.address = 3'd3; wait_neg(10);
        chk("fall_only_rise", 32'(bus.readdata), 32'd0);
        in_port[2] = 1'b0; wait_neg(10);
        chk("fall_only_fall", 32'(bus.readdata), 32'd4);
        chk("fall_only_irq", 32'(bus.irq), 32'd1);
        bus_write(3'd3, 3'b100);
        chk("fall_clr_irq", 32'(bus.irq), 32'd0);
        bus.address = 3'd5;
        @(negedge clk); chk("addr5_zero", 32'(bus.readdata), 32'd0);

        // 6: asynchronous reset mid-count
        bus_write(3'd1, 3'b111);
        in_port = '0; bus.address = 3'd0; wait_neg(10);
        bus_write(3'd3, 3'b111);
        bus.address = 3'd0; in_port[0] = 1'b1;
        wait_neg(4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_irq", 32'(bus.irq), 32'd0);
        chk("async_rst_rd", 32'(bus.readdata), 32'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) chk("post_rst_k6", 32'(bus.readdata), 32'd0);
            if (k == 7) chk("post_rst_k7", 32'(bus.readdata), 32'd1);
        end

        // randomized traffic, checked by the scoreboard
        for (int b = 0; b < W; b++) hold[b] = $urandom_range(1, 9);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            bus.chipselect = 1'b0; bus.write_n = 1'b1;
            for (int b = 0; b < W; b++) begin
                if (hold[b] == 0) begin
                    in_port[b] = ~in_port[b];
                    hold[b] = $urandom_range(1, 9);
                end else begin
                    hold[b]--;
                end
            end
            r = $urandom_range(0, 9);
            if (r < 2) begin
                bus.address = 3'($urandom_range(0, 7));
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
                bus.writedata = W'($urandom);
            end else if (r < 5) begin
                bus.address = 3'($urandom_range(0, 7));
            end else if (r == 5) begin
                bus.chipselect = 1'b1;
            end
        end
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        wait_neg(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
